// File: rtl/axis_fork_arbiter_n.sv
// AXI4-Stream 1-to-M_COUNT frame router: broadcast (fork) or round-robin single-target mode.
// Optional macro AXIS_FORK_DROP_EN: frames with no eligible target are consumed and counted as drops.
module axis_fork_arbiter_n #(
   parameter int M_COUNT    = 4,
   parameter int DATA_WIDTH = 64,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [M_COUNT-1:0]            oen,
   input  logic                          fork_enable,
   input  logic [M_COUNT-1:0]            single_mask,
   output logic                          s_axis_tready,
   input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
   input  logic                          s_axis_tlast,
   input  logic                          s_axis_tvalid,
   input  logic [M_COUNT-1:0]            m_axis_tready,
   output logic [M_COUNT*DATA_WIDTH-1:0] m_axis_tdata,
   output logic [M_COUNT-1:0]            m_axis_tlast,
   output logic [M_COUNT-1:0]            m_axis_tvalid,
   output logic [CNT_WIDTH-1:0]          frame_cnt,
   output logic [CNT_WIDTH-1:0]          drop_cnt
);

   localparam int IDX_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [0:0]                    state;
   logic [IDX_W-1:0]              last_grant;
   logic [IDX_W-1:0]              grant_idx;
   logic [IDX_W-1:0]              rr_idx;
   logic                          grant_found;
   logic [M_COUNT-1:0]            elig;
   logic [M_COUNT-1:0]            tgt_new;
   logic [M_COUNT-1:0]            tgt_lat;
   logic [M_COUNT-1:0]            tgt_cur;
   logic [M_COUNT-1:0]            slice_rdy;
   logic [M_COUNT-1:0]            valid_q;
   logic [M_COUNT-1:0]            last_q;
   logic [M_COUNT*DATA_WIDTH-1:0] data_q;
   logic                          all_rdy;
   logic                          drop_cur;
   logic                          accept;

   // Round-robin search starting one past the previous grant, wrapping at M_COUNT.
   always_comb begin
      elig        = oen & single_mask;
      grant_idx   = '0;
      rr_idx      = '0;
      grant_found = 1'b0;
      for (int k = 1; k <= M_COUNT; k++) begin
         rr_idx = IDX_W'((int'(last_grant) + k) % M_COUNT);
         if (!grant_found && elig[rr_idx]) begin
            grant_found = 1'b1;
            grant_idx   = rr_idx;
         end
      end
   end

   always_comb begin
      if (fork_enable) begin
         tgt_new = oen;
      end else if (grant_found) begin
         tgt_new = M_COUNT'(1) << grant_idx;
      end else begin
         tgt_new = '0;
      end
   end

   assign tgt_cur = (state == ST_IDLE) ? tgt_new : tgt_lat;

`ifdef AXIS_FORK_DROP_EN
   logic drop_lat;
   assign drop_cur = (state == ST_IDLE) ? (tgt_new == '0) : drop_lat;
`else
   assign drop_cur = 1'b0;
`endif

   // Accept only when every targeted slice can take the beat, keeping broadcast in lockstep.
   assign slice_rdy     = ~valid_q | m_axis_tready;
   assign all_rdy       = &(slice_rdy | ~tgt_cur);
   assign s_axis_tready = rst_n & (drop_cur | ((tgt_cur != '0) & all_rdy));
   assign accept        = s_axis_tvalid & s_axis_tready;

   // Frame-level routing state: target latched at first beat, held until tlast is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         tgt_lat    <= '0;
         last_grant <= IDX_W'(M_COUNT - 1);
`ifdef AXIS_FORK_DROP_EN
         drop_lat   <= 1'b0;
`endif
      end else if (accept) begin
         if (state == ST_IDLE) begin
            tgt_lat <= tgt_new;
`ifdef AXIS_FORK_DROP_EN
            drop_lat <= (tgt_new == '0);
`endif
            if (!fork_enable && grant_found) begin
               last_grant <= grant_idx;
            end
            if (!s_axis_tlast) begin
               state <= ST_BUSY;
            end
         end else if (s_axis_tlast) begin
            state <= ST_IDLE;
         end
      end
   end

   // One-beat output slices; drain and refill may happen in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         last_q  <= '0;
         data_q  <= '0;
      end else begin
         for (int i = 0; i < M_COUNT; i++) begin
            if (accept && tgt_cur[i]) begin
               valid_q[i]                          <= 1'b1;
               last_q[i]                           <= s_axis_tlast;
               data_q[i*DATA_WIDTH +: DATA_WIDTH]  <= s_axis_tdata;
            end else if (m_axis_tready[i]) begin
               valid_q[i] <= 1'b0;
            end
         end
      end
   end

   assign m_axis_tvalid = valid_q;
   assign m_axis_tlast  = last_q;
   assign m_axis_tdata  = data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
      end else if (accept && s_axis_tlast) begin
         frame_cnt <= frame_cnt + 1'b1;
      end
   end

`ifdef AXIS_FORK_DROP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (accept && s_axis_tlast && drop_cur) begin
         drop_cnt <= drop_cnt + 1'b1;
      end
   end
`else
   assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_axis_fork_arbiter_n.sv
// Scoreboard bench for axis_fork_arbiter_n (M_COUNT=4); follows AXIS_FORK_DROP_EN if defined.
module tb_axis_fork_arbiter_n;

   localparam int M  = 4;
   localparam int DW = 64;
   localparam int CW = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [M-1:0]    oen = '0;
   logic            fork_enable = 1'b1;
   logic [M-1:0]    single_mask = '0;
   logic            s_axis_tready;
   logic [DW-1:0]   s_axis_tdata = '0;
   logic            s_axis_tlast = 1'b0;
   logic            s_axis_tvalid = 1'b0;
   logic [M-1:0]    m_axis_tready = '1;
   logic [M*DW-1:0] m_axis_tdata;
   logic [M-1:0]    m_axis_tlast;
   logic [M-1:0]    m_axis_tvalid;
   logic [CW-1:0]   frame_cnt;
   logic [CW-1:0]   drop_cnt;

   int checks = 0;
   int failures = 0;
   logic [DW:0] exp_q[M][$];

   axis_fork_arbiter_n #(.M_COUNT(M), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .oen(oen), .fork_enable(fork_enable),
      .single_mask(single_mask), .s_axis_tready(s_axis_tready),
      .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
      .s_axis_tvalid(s_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [DW:0] actual, input logic [DW:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   // Push the expected beat for every channel in mask, then drive it until accepted.
   task automatic applyStimulus(input logic [DW-1:0] data, input logic last, input logic [M-1:0] mask);
      int t;
      for (int i = 0; i < M; i++) begin
         if (mask[i]) exp_q[i].push_back({last, data});
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = data;
      s_axis_tlast  = last;
      t = 0;
      @(negedge clk);
      while (!s_axis_tready && t < 200) begin
         t++;
         @(negedge clk);
      end
      if (t >= 200) checkOutput("s_tready_timeout", (DW+1)'(0), (DW+1)'(1));
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
   endtask

   task automatic waitDrain();
      int t;
      logic pending;
      t = 0;
      pending = 1'b1;
      while (pending && t < 100) begin
         @(negedge clk);
         t++;
         pending = 1'b0;
         for (int i = 0; i < M; i++) if (exp_q[i].size() != 0) pending = 1'b1;
      end
      checkOutput("drain_done", (DW+1)'(pending), (DW+1)'(0));
      @(posedge clk);
      #1;
   endtask

   // Monitor: pop and compare on every output handshake; flag any unexpected valid.
   always @(negedge clk) begin
      for (int i = 0; i < M; i++) begin
         if (m_axis_tvalid[i]) begin
            if (exp_q[i].size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL ch%0d_unexpected_valid actual=%h expected=none",
                        i, {m_axis_tlast[i], m_axis_tdata[i*DW +: DW]});
            end else if (m_axis_tready[i]) begin
               checkOutput($sformatf("ch%0d_beat", i),
                           {m_axis_tlast[i], m_axis_tdata[i*DW +: DW]}, exp_q[i].pop_front());
            end
         end
      end
   end

   initial begin
      #12;
      checkOutput("rst_tvalid", (DW+1)'(m_axis_tvalid), (DW+1)'(0));
      checkOutput("rst_tlast", (DW+1)'(m_axis_tlast), (DW+1)'(0));
      checkOutput("rst_tdata_ch0", (DW+1)'(m_axis_tdata[DW-1:0]), (DW+1)'(0));
      checkOutput("rst_s_tready", (DW+1)'(s_axis_tready), (DW+1)'(0));
      checkOutput("rst_frame_cnt", (DW+1)'(frame_cnt), (DW+1)'(0));
      checkOutput("rst_drop_cnt", (DW+1)'(drop_cnt), (DW+1)'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Fork to channels 0,1,3
      fork_enable = 1'b1;
      oen = 4'b1011;
      applyStimulus(64'hD0D0_0000_0000_0000, 1'b0, 4'b1011);
      applyStimulus(64'hD1D1_0000_0000_0001, 1'b0, 4'b1011);
      applyStimulus(64'hD2D2_0000_0000_0002, 1'b1, 4'b1011);
      waitDrain();
      checkOutput("fork_frame_cnt", (DW+1)'(frame_cnt), (DW+1)'(1));
      checkOutput("fork_idle_tvalid", (DW+1)'(m_axis_tvalid), (DW+1)'(0));

      // Fork with channel 1 stalled
      m_axis_tready = 4'b1101;
      fork
         begin
            applyStimulus(64'h2200_0000_0000_0000, 1'b0, 4'b1011);
            applyStimulus(64'h2200_0000_0000_0001, 1'b0, 4'b1011);
            applyStimulus(64'h2200_0000_0000_0002, 1'b1, 4'b1011);
         end
         begin
            repeat (3) @(negedge clk);
            checkOutput("stall_s_tready", (DW+1)'(s_axis_tready), (DW+1)'(0));
            repeat (2) @(posedge clk);
            #1;
            m_axis_tready = 4'b1111;
         end
      join
      waitDrain();

      // Single mode round robin
      fork_enable = 1'b0;
      oen = 4'b1111;
      single_mask = 4'b1111;
      applyStimulus(64'h3300_0000_0000_0000, 1'b1, 4'b0001);
      applyStimulus(64'h3300_0000_0000_0001, 1'b1, 4'b0010);
      applyStimulus(64'h3300_0000_0000_0002, 1'b1, 4'b0100);
      applyStimulus(64'h3300_0000_0000_0003, 1'b1, 4'b1000);
      single_mask = 4'b0101;
      applyStimulus(64'h3300_0000_0000_0004, 1'b1, 4'b0001);
      applyStimulus(64'h3300_0000_0000_0005, 1'b1, 4'b0100);
      applyStimulus(64'h3300_0000_0000_0006, 1'b1, 4'b0001);
      waitDrain();

      // Config change mid-frame is ignored until the next frame
      applyStimulus(64'h4400_0000_0000_0000, 1'b0, 4'b0100);
      fork_enable = 1'b1;
      oen = 4'b0011;
      applyStimulus(64'h4400_0000_0000_0001, 1'b0, 4'b0100);
      applyStimulus(64'h4400_0000_0000_0002, 1'b0, 4'b0100);
      applyStimulus(64'h4400_0000_0000_0003, 1'b1, 4'b0100);
      applyStimulus(64'h4400_0000_0000_0004, 1'b1, 4'b0011);
      waitDrain();
      checkOutput("frames_before_oen0", (DW+1)'(frame_cnt), (DW+1)'(11));

      // No enabled output
      oen = 4'b0000;
`ifdef AXIS_FORK_DROP_EN
      applyStimulus(64'h5500_0000_0000_0000, 1'b0, 4'b0000);
      applyStimulus(64'h5500_0000_0000_0001, 1'b1, 4'b0000);
      waitDrain();
      checkOutput("drop_cnt", (DW+1)'(drop_cnt), (DW+1)'(1));
      checkOutput("drop_tvalid", (DW+1)'(m_axis_tvalid), (DW+1)'(0));
`else
      fork
         begin
            applyStimulus(64'h5500_0000_0000_0000, 1'b0, 4'b0100);
            applyStimulus(64'h5500_0000_0000_0001, 1'b1, 4'b0100);
         end
         begin
            repeat (4) @(negedge clk);
            checkOutput("oen0_s_tready", (DW+1)'(s_axis_tready), (DW+1)'(0));
            @(posedge clk);
            #1;
            oen = 4'b0100;
         end
      join
      waitDrain();
      checkOutput("drop_cnt_tied", (DW+1)'(drop_cnt), (DW+1)'(0));
`endif
      checkOutput("frames_after_oen0", (DW+1)'(frame_cnt), (DW+1)'(12));

      // Asynchronous reset during beat 2 of a 5-beat frame
      oen = 4'b1111;
      fork_enable = 1'b1;
      for (int i = 0; i < M; i++) begin
         exp_q[i].push_back({1'b0, 64'h6600_0000_0000_0000});
         exp_q[i].push_back({1'b0, 64'h6600_0000_0000_0001});
      end
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = 1'b0;
      s_axis_tdata  = 64'h6600_0000_0000_0000;
      @(posedge clk);
      #1;
      s_axis_tdata = 64'h6600_0000_0000_0001;
      @(posedge clk);
      #1;
      s_axis_tdata = 64'h6600_0000_0000_0002;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_tvalid", (DW+1)'(m_axis_tvalid), (DW+1)'(0));
      checkOutput("async_rst_s_tready", (DW+1)'(s_axis_tready), (DW+1)'(0));
      for (int i = 0; i < M; i++) exp_q[i].delete();
      s_axis_tvalid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      checkOutput("post_rst_frame_cnt", (DW+1)'(frame_cnt), (DW+1)'(0));
      @(posedge clk);
      #1;
      applyStimulus(64'h7700_0000_0000_0000, 1'b0, 4'b1111);
      applyStimulus(64'h7700_0000_0000_0001, 1'b1, 4'b1111);
      waitDrain();
      checkOutput("post_rst_frame_cnt_1", (DW+1)'(frame_cnt), (DW+1)'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axis_fork_arbiter_n.md
# axis_fork_arbiter_n

Parametrised AXI4-Stream 1-to-M_COUNT router at frame granularity, the next generation of the team's fixed 3-port fork arbiter. Each frame is either broadcast to every enabled output (fork mode) or sent to exactly one output chosen by round-robin among masked outputs (single mode). Routing is latched at frame start, and each output has a one-beat register slice. The block sits between the packet-ingress stream and the per-core output channels of the datapath.

## Interface
- M_COUNT, 4, number of output channels (2..16)
- DATA_WIDTH, 64, tdata width in bits
- CNT_WIDTH, 16, width of frame/drop status counters
- clk  in  1  clock; all logic rising-edge
- rst_n  in  1  reset, asynchronous assert, active-low
- oen  in  M_COUNT  per-output enable
- fork_enable  in  1  1 = broadcast mode, 0 = single mode
- single_mask  in  M_COUNT  outputs eligible in single mode
- s_axis_tready  out  1  input ready
- s_axis_tdata  in  DATA_WIDTH  input data
- s_axis_tlast  in  1  end of frame
- s_axis_tvalid  in  1  input valid
- m_axis_tready  in  M_COUNT  per-output ready
- m_axis_tdata  out  M_COUNT*DATA_WIDTH  output data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
- m_axis_tlast  out  M_COUNT  per-output last
- m_axis_tvalid  out  M_COUNT  per-output valid
- frame_cnt  out  CNT_WIDTH  frames fully accepted at input (wraps)
- drop_cnt  out  CNT_WIDTH  frames discarded (see Configuration)

## Operation
- State machine: IDLE (at frame boundary) and BUSY (mid-frame).
- In IDLE, on the first beat of a frame (s_axis_tvalid=1), compute the target mask:
  - fork mode: tgt = oen.
  - single mode: elig = oen & single_mask; tgt = one-hot of the first set bit of elig, searching from last_grant+1 with wrap-around.
  - last_grant updates to the chosen index only in single mode, and only when that first beat is accepted.
- The target mask is latched on acceptance of the first beat. IDLE->BUSY if that beat has tlast=0; it stays IDLE if tlast=1.
- In BUSY the latched target is used. oen, fork_enable and single_mask changes are ignored until the frame's tlast beat is accepted, then BUSY->IDLE.
- Slice i ready: rdy_i = !m_axis_tvalid[i] | m_axis_tready[i].
- s_axis_tready = AND of rdy_i over all set bits of tgt, with tgt non-zero. A beat is written into every target slice in the same cycle, so broadcast stays lockstep with no partial delivery.
- If tgt = 0: handled per Configuration.
- frame_cnt increments on each accepted tlast beat, including dropped frames.
- Non-target outputs never assert tvalid. tdata/tlast of an invalid slice hold their last value.

## Timing
- Reset (rst_n=0, asynchronous) drives:
  - all m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0
  - s_axis_tready=0, frame_cnt=0, drop_cnt=0
  - state=IDLE, last_grant=M_COUNT-1, so the first single-mode grant is channel 0.
- Reset mid-frame discards the frame remainder and slice contents. No partial beat is emitted afterwards.
- Latency: an accepted input beat appears on m_axis at the next rising edge (1 cycle).
- Throughput: 1 beat/cycle while all targets keep tready=1.
- s_axis_tready is combinational from m_axis_tready, tvalid, state and the config inputs; there is no combinational path from s_axis_tvalid to s_axis_tready.
- m_axis_tvalid, once asserted, holds with stable tdata/tlast until m_axis_tready=1.
- Simultaneous slice drain and refill in one cycle is allowed: valid stays 1 and new data is loaded.
- Single-beat frames (tlast on first beat) arbitrate every cycle. Back-to-back frames need no idle cycle.

## Configuration
- Macro AXIS_FORK_DROP_EN.
- Defined: when tgt=0 at frame start, s_axis_tready=1 and the whole frame is consumed and discarded. No output asserts tvalid. drop_cnt increments on the frame's tlast beat. The discard decision holds for the frame even if oen changes.
- Not defined: tgt=0 holds s_axis_tready=0 in IDLE until some target becomes eligible. drop_cnt is tied to 0.

## Test plan
- Fork, M_COUNT=4, oen=4'b1011, all tready=1, 3-beat frame D0..D2 -> channels 0,1,3 each emit D0..D2 one cycle after input; channel 2 tvalid stays 0; frame_cnt=1.
- Fork with m_axis_tready[1]=0 for 5 cycles -> s_axis_tready=0 for those cycles; no channel gets beat 2 before channel 1 has taken beat 1; no beat is duplicated or lost.
- Single mode, oen=single_mask=4'b1111, four 1-beat frames back-to-back -> grants go to channels 0,1,2,3 in order; then single_mask=4'b0101 -> next grants go to 0,2,0.
- Single mode, toggle fork_enable and oen mid-frame on a 4-beat frame -> all 4 beats go to the latched channel; the new config takes effect only on the next frame.
- oen=0 with a 2-beat frame -> with AXIS_FORK_DROP_EN: frame consumed in 2 cycles, drop_cnt=1, no tvalid on any output. Without the macro: s_axis_tready=0 until oen is set, then normal delivery.
- Assert rst_n=0 asynchronously during beat 2 of a 5-beat frame -> all tvalid=0 immediately; after release, the next frame routes cleanly and frame_cnt restarts from 0.
